// File: rtl/sad_pkg.sv
// Shared definitions for the SAD address sequencer.
// Holds the FSM state encoding and the default address/dimension widths.
package sad_pkg;

    localparam int ADDR_W = 32;  // byte address width
    localparam int DIM_W  = 8;   // frame/template dimension and loop counter width
    localparam int WORD_B = 4;   // byte stride between consecutive words

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/sad_addr_gen.sv
// Next-address generator for one address stream.
// Either steps the current address by an offset or jumps to a new row pointer
// (plus offset) when the inner column loop wraps.
// Ports:
//   sel_row  in   1       1: start from row_ptr, 0: start from cur
//   cur      in   ADDR_W  current address
//   row_ptr  in   ADDR_W  address of the start of the next row
//   offset   in   ADDR_W  amount added to the selected source
//   addr     out  ADDR_W  selected source + offset (modulo 2^ADDR_W)
module sad_addr_gen #(
    parameter int ADDR_W = sad_pkg::ADDR_W
) (
    input  logic              sel_row,
    input  logic [ADDR_W-1:0] cur,
    input  logic [ADDR_W-1:0] row_ptr,
    input  logic [ADDR_W-1:0] offset,
    output logic [ADDR_W-1:0] addr
);

    assign addr = (sel_row ? row_ptr : cur) + offset;

endmodule

// File: rtl/sad_addr_sequencer.sv
// Address sequencer for the SAD window search.
// For every MxM window position inside an NxN frame, emits one frame-word and
// one template-word address per template element over a valid/ready handshake.
// Ports:
//   Clk, Rst     clock / synchronous active-high reset
//   start        begin a scan (sampled in IDLE only)
//   frame_base, tmpl_base, frame_dim, tmpl_dim   scan config, latched on start
//   busy, done   scan in progress / one-cycle completion pulse
//   addr_valid, addr_ready   output handshake
//   frame_addr, tmpl_addr    current element addresses
//   win_row, win_col         current window position
//   win_last                 current element is the last of its window
module sad_addr_sequencer
    import sad_pkg::*;
#(
    parameter int ADDR_W = sad_pkg::ADDR_W,
    parameter int DIM_W  = sad_pkg::DIM_W,
    parameter int WORD_B = sad_pkg::WORD_B
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic [ADDR_W-1:0] tmpl_base,
    input  logic [DIM_W-1:0]  frame_dim,
    input  logic [DIM_W-1:0]  tmpl_dim,
    output logic              busy,
    output logic              done,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [ADDR_W-1:0] frame_addr,
    output logic [ADDR_W-1:0] tmpl_addr,
    output logic [DIM_W-1:0]  win_row,
    output logic [DIM_W-1:0]  win_col,
    output logic              win_last
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_B);
    localparam logic [DIM_W-1:0]  ONE  = DIM_W'(1);

    logic [1:0]        state;
    logic [DIM_W-1:0]  tc, tr, wc, wr;
    logic [DIM_W-1:0]  m_last, w_last;     // M-1 and N-M, latched on start
    logic [ADDR_W-1:0] n_stride, m_stride; // bytes per frame row / template row
    logic [ADDR_W-1:0] tmpl_base_r;
    // Running pointers: wrow_ptr = start of window row wr, win_ptr = window origin,
    // frow_ptr / trow_ptr = start of the current template row in frame / template.
    logic [ADDR_W-1:0] wrow_ptr, win_ptr, frow_ptr, trow_ptr;
    logic              win_last_r;

    logic [DIM_W-1:0]  tc_n, tr_n, wc_n, wr_n;
    logic [ADDR_W-1:0] wrow_n, win_n, frow_n, trow_n;
    logic [ADDR_W-1:0] frame_addr_n, tmpl_addr_n, col_off;
    logic              row_sel, xfer, tc_end, tr_end, wc_end, wr_end, last_elem;
    logic              cfg_ok;

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign addr_valid = (state == ISSUE);
    assign win_last   = win_last_r & addr_valid;
    assign win_row    = wr;
    assign win_col    = wc;

    assign xfer      = addr_valid & addr_ready;
    assign tc_end    = (tc == m_last);
    assign tr_end    = (tr == m_last);
    assign wc_end    = (wc == w_last);
    assign wr_end    = (wr == w_last);
    assign last_elem = tc_end & tr_end & wc_end & wr_end;
    assign cfg_ok    = (tmpl_dim != '0) && (tmpl_dim <= frame_dim);

    // Loop nest advance: tc fastest, then tr, wc, wr. Each wrap moves the
    // relevant running pointer by a stride instead of recomputing products.
    always_comb begin
        tc_n    = tc + ONE;
        tr_n    = tr;
        wc_n    = wc;
        wr_n    = wr;
        wrow_n  = wrow_ptr;
        win_n   = win_ptr;
        frow_n  = frow_ptr;
        trow_n  = trow_ptr;
        row_sel = 1'b0;
        if (tc_end) begin
            tc_n    = '0;
            row_sel = 1'b1;
            if (!tr_end) begin
                tr_n   = tr + ONE;
                frow_n = frow_ptr + n_stride;
                trow_n = trow_ptr + m_stride;
            end else begin
                tr_n   = '0;
                trow_n = tmpl_base_r;
                if (!wc_end) begin
                    wc_n   = wc + ONE;
                    win_n  = win_ptr + STEP;
                    frow_n = win_ptr + STEP;
                end else begin
                    // wr wraps only on the final element, where the scan ends anyway
                    wc_n   = '0;
                    wr_n   = wr + ONE;
                    wrow_n = wrow_ptr + n_stride;
                    win_n  = wrow_ptr + n_stride;
                    frow_n = wrow_ptr + n_stride;
                end
            end
        end
    end

    assign col_off = row_sel ? '0 : STEP;

    sad_addr_gen #(.ADDR_W(ADDR_W)) u_frame_gen (
        .sel_row (row_sel),
        .cur     (frame_addr),
        .row_ptr (frow_n),
        .offset  (col_off),
        .addr    (frame_addr_n)
    );

    sad_addr_gen #(.ADDR_W(ADDR_W)) u_tmpl_gen (
        .sel_row (row_sel),
        .cur     (tmpl_addr),
        .row_ptr (trow_n),
        .offset  (col_off),
        .addr    (tmpl_addr_n)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= IDLE;
            tc          <= '0;
            tr          <= '0;
            wc          <= '0;
            wr          <= '0;
            m_last      <= '0;
            w_last      <= '0;
            n_stride    <= '0;
            m_stride    <= '0;
            tmpl_base_r <= '0;
            wrow_ptr    <= '0;
            win_ptr     <= '0;
            frow_ptr    <= '0;
            trow_ptr    <= '0;
            frame_addr  <= '0;
            tmpl_addr   <= '0;
            win_last_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    tc          <= '0;
                    tr          <= '0;
                    wc          <= '0;
                    wr          <= '0;
                    m_last      <= tmpl_dim - ONE;
                    w_last      <= frame_dim - tmpl_dim;
                    // constant WORD_B factor: reduces to a shift for power-of-two strides
                    n_stride    <= ADDR_W'(frame_dim) * STEP;
                    m_stride    <= ADDR_W'(tmpl_dim) * STEP;
                    tmpl_base_r <= tmpl_base;
                    wrow_ptr    <= frame_base;
                    win_ptr     <= frame_base;
                    frow_ptr    <= frame_base;
                    trow_ptr    <= tmpl_base;
                    frame_addr  <= frame_base;
                    tmpl_addr   <= tmpl_base;
                    win_last_r  <= (tmpl_dim == ONE);
                    state       <= cfg_ok ? ISSUE : DONE;
                end
                ISSUE: if (xfer) begin
                    if (last_elem) begin
                        state <= DONE;
                    end else begin
                        tc         <= tc_n;
                        tr         <= tr_n;
                        wc         <= wc_n;
                        wr         <= wr_n;
                        wrow_ptr   <= wrow_n;
                        win_ptr    <= win_n;
                        frow_ptr   <= frow_n;
                        trow_ptr   <= trow_n;
                        frame_addr <= frame_addr_n;
                        tmpl_addr  <= tmpl_addr_n;
                        win_last_r <= (tc_n == m_last) && (tr_n == m_last);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sad_addr_sequencer.sv
// Self-checking bench for sad_addr_sequencer: directed scenarios plus random
// configurations, compared against a loop-nest reference model.
module tb_sad_addr_sequencer;

    logic        Clk = 1'b0;
    logic        Rst, start, addr_ready;
    logic [31:0] frame_base, tmpl_base;
    logic [7:0]  frame_dim, tmpl_dim;
    logic        busy, done, addr_valid, win_last;
    logic [31:0] frame_addr, tmpl_addr;
    logic [7:0]  win_row, win_col;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] fa;
        logic [31:0] ta;
        logic [7:0]  wr;
        logic [7:0]  wc;
        logic        last;
    } xfer_t;

    sad_addr_sequencer dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .start      (start),
        .frame_base (frame_base),
        .tmpl_base  (tmpl_base),
        .frame_dim  (frame_dim),
        .tmpl_dim   (tmpl_dim),
        .busy       (busy),
        .done       (done),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .frame_addr (frame_addr),
        .tmpl_addr  (tmpl_addr),
        .win_row    (win_row),
        .win_col    (win_col),
        .win_last   (win_last)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_done"},  32'(done), 0);
        chk({tag, "_valid"}, 32'(addr_valid), 0);
        chk({tag, "_last"},  32'(win_last), 0);
        chk({tag, "_fa"},    frame_addr, 0);
        chk({tag, "_ta"},    tmpl_addr, 0);
        chk({tag, "_wrow"},  32'(win_row), 0);
        chk({tag, "_wcol"},  32'(win_col), 0);
    endtask

    // One scan. Inputs are driven and outputs sampled on the falling edge.
    // stall_at: transfer index where ready drops for 3 cycles; rst_at: transfer
    // index where Rst aborts the scan; poke_at: transfer index where a stray
    // start with a different config is pulsed.
    task automatic run_scan(input int n, input int m, input logic [31:0] fb,
                            input logic [31:0] tbs, input int rdy_pct,
                            input int stall_at, input int rst_at, input int poke_at,
                            output logic [31:0] last_fa, output logic [31:0] last_ta,
                            output logic last_wl);
        xfer_t exp_q[$];
        xfer_t e;
        int    idx = 0;
        int    cyc = 0;
        int    stall_left = 0;
        bit    stalled = 0;
        bit    rdy;
        int    budget;
        last_fa = '0;
        last_ta = '0;
        last_wl = 1'b0;
        if (m >= 1 && m <= n) begin
            for (int wr = 0; wr <= n - m; wr++)
                for (int wc = 0; wc <= n - m; wc++)
                    for (int tr = 0; tr < m; tr++)
                        for (int tc = 0; tc < m; tc++) begin
                            e.fa   = fb + 32'(((wr + tr) * n + (wc + tc)) * 4);
                            e.ta   = tbs + 32'((tr * m + tc) * 4);
                            e.wr   = 8'(wr);
                            e.wc   = 8'(wc);
                            e.last = (tr == m - 1) && (tc == m - 1);
                            exp_q.push_back(e);
                        end
        end
        budget = exp_q.size() * 12 + 20;

        @(negedge Clk);
        frame_base = fb;
        tmpl_base  = tbs;
        frame_dim  = 8'(n);
        tmpl_dim   = 8'(m);
        start      = 1'b1;
        addr_ready = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        // scramble inputs: the DUT must run from its latched copy
        frame_base = $urandom;
        tmpl_base  = $urandom;
        frame_dim  = 8'($urandom_range(1, 9));
        tmpl_dim   = 8'($urandom_range(0, 9));

        if (exp_q.size() == 0) begin
            chk("degen_done", 32'(done), 1);
            chk("degen_busy", 32'(busy), 1);
            chk("degen_valid", 32'(addr_valid), 0);
            @(negedge Clk);
            chk("degen_done_after", 32'(done), 0);
            chk("degen_busy_after", 32'(busy), 0);
            chk("degen_valid_after", 32'(addr_valid), 0);
            return;
        end

        while (idx < exp_q.size() && cyc < budget) begin
            chk("valid", 32'(addr_valid), 1);
            chk("busy", 32'(busy), 1);
            chk("no_done", 32'(done), 0);
            chk("frame_addr", frame_addr, exp_q[idx].fa);
            chk("tmpl_addr", tmpl_addr, exp_q[idx].ta);
            chk("win_row", 32'(win_row), 32'(exp_q[idx].wr));
            chk("win_col", 32'(win_col), 32'(exp_q[idx].wc));
            chk("win_last", 32'(win_last), 32'(exp_q[idx].last));
            if (idx == rst_at) begin
                Rst = 1'b1;
                addr_ready = 1'($urandom);
                @(negedge Clk);
                Rst = 1'b0;
                chk_reset_outputs("abort");
                @(negedge Clk);
                chk("abort_no_done", 32'(done), 0);
                chk("abort_idle", 32'(busy), 0);
                return;
            end
            if (idx == stall_at && !stalled) begin
                stalled    = 1;
                stall_left = 3;
            end
            if (stall_left > 0) begin
                rdy = 0;
                stall_left--;
            end else begin
                rdy = ($urandom_range(99) < rdy_pct);
            end
            if (idx == poke_at) begin
                start      = 1'b1;
                frame_base = $urandom;
                tmpl_base  = $urandom;
                frame_dim  = 8'($urandom_range(1, 9));
                tmpl_dim   = 8'($urandom_range(1, 9));
            end
            if (rdy && idx == exp_q.size() - 1) begin
                last_fa = frame_addr;
                last_ta = tmpl_addr;
                last_wl = win_last;
            end
            addr_ready = rdy;
            @(negedge Clk);
            start = 1'b0;
            cyc++;
            if (rdy) idx++;
        end
        chk("xfer_count", 32'(idx), 32'(exp_q.size()));
        addr_ready = 1'($urandom);
        chk("end_done", 32'(done), 1);
        chk("end_busy", 32'(busy), 1);
        chk("end_valid", 32'(addr_valid), 0);
        @(negedge Clk);
        chk("end_done_after", 32'(done), 0);
        chk("end_busy_after", 32'(busy), 0);
        chk("end_valid_after", 32'(addr_valid), 0);
    endtask

    initial begin
        logic [31:0] lfa, lta;
        logic        lwl;
        Rst        = 1'b1;
        start      = 1'b0;
        addr_ready = 1'b0;
        frame_base = '0;
        tmpl_base  = '0;
        frame_dim  = '0;
        tmpl_dim   = '0;
        repeat (2) @(negedge Clk);
        chk_reset_outputs("reset");
        // Rst wins over a simultaneous start
        start = 1'b1;
        frame_dim = 8'd4;
        tmpl_dim  = 8'd2;
        @(negedge Clk);
        start = 1'b0;
        Rst   = 1'b0;
        chk_reset_outputs("rst_vs_start");

        // 1: basic scan under continuous ready
        run_scan(4, 2, 32'h1000, 32'h2000, 100, -1, -1, -1, lfa, lta, lwl);
        chk("t1_last_fa", lfa, 32'h103C);
        chk("t1_last_ta", lta, 32'h200C);
        chk("t1_last_wl", 32'(lwl), 1);
        // 2: stall on transfer 5
        run_scan(4, 2, 32'h1000, 32'h2000, 100, 4, -1, -1, lfa, lta, lwl);
        // 3: degenerate template sizes
        run_scan(4, 0, 32'h1000, 32'h2000, 100, -1, -1, -1, lfa, lta, lwl);
        run_scan(4, 5, 32'h1000, 32'h2000, 100, -1, -1, -1, lfa, lta, lwl);
        // 4: template fills the frame
        run_scan(3, 3, 32'h1000, 32'h2000, 100, -1, -1, -1, lfa, lta, lwl);
        // 5: abort on transfer 10, then replay
        run_scan(4, 2, 32'h1000, 32'h2000, 100, -1, 9, -1, lfa, lta, lwl);
        run_scan(4, 2, 32'h1000, 32'h2000, 100, -1, -1, -1, lfa, lta, lwl);
        // 6: stray start during ISSUE
        run_scan(4, 2, 32'h1000, 32'h2000, 80, -1, -1, 7, lfa, lta, lwl);
        run_scan(5, 3, 32'h4000, 32'h8000, 70, -1, -1, 20, lfa, lta, lwl);
        // M=1 and address wrap-around
        run_scan(3, 1, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 100, -1, -1, -1, lfa, lta, lwl);
        // random configurations with random backpressure
        for (int i = 0; i < 10; i++) begin
            int n, m;
            n = $urandom_range(1, 6);
            m = $urandom_range(0, n + 1);
            run_scan(n, m, $urandom, $urandom, 60, -1, -1,
                     int'($urandom_range(0, 15)), lfa, lta, lwl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
